// File: rtl/serial_link_partner_if.sv
// Host-side byte stream for the link partner: TX bytes toward the console, RX bytes back.
interface serial_link_partner_if;
    logic       host_tx_valid;
    logic [7:0] host_tx_data;
    logic       host_tx_ready;
    logic       host_rx_valid;
    logic [7:0] host_rx_data;
    logic       host_rx_ready;

    modport master (
        output host_tx_valid, host_tx_data, host_rx_ready,
        input  host_tx_ready, host_rx_valid, host_rx_data
    );
    modport slave (
        input  host_tx_valid, host_tx_data, host_rx_ready,
        output host_tx_ready, host_rx_valid, host_rx_data
    );
endinterface

// File: rtl/serial_link_partner.sv
// Remote Game Boy on the link cable: shifts host bytes into the console's sin and collects
// its sout bytes, either following the console SCLK or generating clk_in as clock master.
module serial_link_partner #(
    parameter int         HALF_PERIOD = 256,
    parameter int         GAP_TICKS   = 512,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_en,
    input  logic clk_dir,
    input  logic console_sclk,
    input  logic console_sout,
    output logic clk_in,
    output logic sin,
    output logic xfer_done,
    output logic rx_overflow,
    serial_link_partner_if.slave host
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (HALF_PERIOD > GAP_TICKS) ? HALF_PERIOD : GAP_TICKS;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] HP_T  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] GAP_T = TW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_e;

    logic [7:0]    tx_mem [0:FIFO_DEPTH-1];
    logic [7:0]    rx_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          sclk_prev_q, sclk_prev_d, dir_prev_q, dir_prev_d;
    logic [7:0]    cur_q, cur_d, shadow_q, shadow_d, rx_sh_q, rx_sh_d;
    logic          cur_loaded_q, cur_loaded_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          sin_q, sin_d, clk_in_q, clk_in_d;
    logic          xfer_done_q, xfer_done_d, ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    rcnt_q, rcnt_d;

    logic       sclk, dir_chg, fall, rise, done;
    logic       tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic [7:0] tx_head, cur_src, rx_byte;

    assign sclk    = clk_dir ? console_sclk : clk_in_q;
    assign dir_chg = cpu_en && (clk_dir != dir_prev_q);
    assign fall    = cpu_en && !dir_chg && sclk_prev_q && !sclk;
    assign rise    = cpu_en && !dir_chg && !sclk_prev_q && sclk;
    assign done    = rise && (bitcnt_q == 3'd7);

    assign tx_head = tx_mem[tx_rp_q];
    assign tx_push = host.host_tx_valid && (tx_cnt_q != FULL);
    assign tx_pop  = (bitcnt_q == 3'd0) && !cur_loaded_q && (tx_cnt_q != '0);
    assign rx_pop  = host.host_rx_ready && (rx_cnt_q != '0);
    // A same-cycle host pop frees the slot the incoming byte needs.
    assign rx_push = done && ((rx_cnt_q != FULL) || rx_pop);
    assign rx_drop = done && !rx_push;
    assign rx_byte = {rx_sh_q[6:0], console_sout};

    // A fresh pop feeds the very first fall; an unloaded byte start shifts the idle pattern.
    assign cur_src = tx_pop ? tx_head :
                     ((bitcnt_q == 3'd0) && !cur_loaded_q) ? IDLE_BYTE : cur_q;

    always_comb begin
        tx_wp_d      = tx_wp_q + AW'(tx_push);
        tx_rp_d      = tx_rp_q + AW'(tx_pop);
        tx_cnt_d     = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wp_d      = rx_wp_q + AW'(rx_push);
        rx_rp_d      = rx_rp_q + AW'(rx_pop);
        rx_cnt_d     = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        sclk_prev_d  = sclk_prev_q;
        dir_prev_d   = dir_prev_q;
        cur_d        = tx_pop ? tx_head : cur_q;
        shadow_d     = tx_pop ? tx_head : shadow_q;
        cur_loaded_d = cur_loaded_q | tx_pop;
        sin_d        = sin_q;
        rx_sh_d      = rx_sh_q;
        bitcnt_d     = bitcnt_q;
        xfer_done_d  = done;
        ovf_d        = ovf_q | rx_drop;
        if (cpu_en) begin
            sclk_prev_d = dir_chg ? 1'b1 : sclk;
            dir_prev_d  = clk_dir;
        end
        if (fall) begin
            sin_d = cur_src[7];
            cur_d = {cur_src[6:0], 1'b0};
        end
        if (rise) begin
            rx_sh_d  = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) cur_loaded_d = 1'b0;
        end
        // Direction change abandons the byte; the shadow lets it be resent whole.
        if (dir_chg) begin
            bitcnt_d = 3'd0;
            rx_sh_d  = 8'h00;
            if (cur_loaded_q) cur_d = shadow_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        clk_in_d = clk_in_q;
        tmr_d    = tmr_q;
        rcnt_d   = rcnt_q;
        if (cpu_en) begin
            if (clk_dir || dir_chg) begin
                state_d  = S_IDLE;
                clk_in_d = 1'b1;
                rcnt_d   = 4'd0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        clk_in_d = 1'b1;
                        if (cur_loaded_q) begin
                            clk_in_d = 1'b0;
                            tmr_d    = HP_T;
                            rcnt_d   = 4'd0;
                            state_d  = S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (tmr_q == '0) begin
                            clk_in_d = 1'b1;
                            tmr_d    = HP_T;
                            rcnt_d   = rcnt_q + 4'd1;
                            state_d  = S_HIGH;
                        end else begin
                            tmr_d = tmr_q - 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (tmr_q == '0) begin
                            if (rcnt_q == 4'd8) begin
                                tmr_d   = GAP_T;
                                state_d = S_GAP;
                            end else begin
                                clk_in_d = 1'b0;
                                tmr_d    = HP_T;
                                state_d  = S_LOW;
                            end
                        end else begin
                            tmr_d = tmr_q - 1'b1;
                        end
                    end
                    S_GAP: begin
                        clk_in_d = 1'b1;
                        if (tmr_q == '0) state_d = S_IDLE;
                        else tmr_d = tmr_q - 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= host.host_tx_data;
        if (rx_push) rx_mem[rx_wp_q] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
            rx_cnt_q     <= '0;
            sclk_prev_q  <= 1'b1;
            dir_prev_q   <= clk_dir;
            cur_q        <= 8'h00;
            shadow_q     <= 8'h00;
            cur_loaded_q <= 1'b0;
            rx_sh_q      <= 8'h00;
            bitcnt_q     <= 3'd0;
            sin_q        <= 1'b1;
            clk_in_q     <= 1'b1;
            xfer_done_q  <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            rcnt_q       <= 4'd0;
        end else begin
            tx_wp_q      <= tx_wp_d;
            tx_rp_q      <= tx_rp_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wp_q      <= rx_wp_d;
            rx_rp_q      <= rx_rp_d;
            rx_cnt_q     <= rx_cnt_d;
            sclk_prev_q  <= sclk_prev_d;
            dir_prev_q   <= dir_prev_d;
            cur_q        <= cur_d;
            shadow_q     <= shadow_d;
            cur_loaded_q <= cur_loaded_d;
            rx_sh_q      <= rx_sh_d;
            bitcnt_q     <= bitcnt_d;
            sin_q        <= sin_d;
            clk_in_q     <= clk_in_d;
            xfer_done_q  <= xfer_done_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            rcnt_q       <= rcnt_d;
        end
    end

    assign clk_in             = clk_in_q;
    assign sin                = sin_q;
    assign xfer_done          = xfer_done_q;
    assign rx_overflow        = ovf_q;
    assign host.host_tx_ready = (tx_cnt_q != FULL);
    assign host.host_rx_valid = (rx_cnt_q != '0);
    assign host.host_rx_data  = rx_mem[rx_rp_q];
endmodule

// File: tb/tb_serial_link_partner.sv
// Randomized bench for serial_link_partner against a queue-level model of the link partner.
module tb_serial_link_partner;
    localparam int         HP   = 4;
    localparam int         GAP  = 8;
    localparam int         FD   = 4;
    localparam logic [7:0] IDLE = 8'hFF;

    logic clk, reset, cpu_en, clk_dir, console_sclk, console_sout;
    logic clk_in, sin, xfer_done, rx_overflow;
    serial_link_partner_if hif();

    serial_link_partner #(.HALF_PERIOD(HP), .GAP_TICKS(GAP), .FIFO_DEPTH(FD), .IDLE_BYTE(IDLE)) dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .clk_dir(clk_dir),
        .console_sclk(console_sclk), .console_sout(console_sout),
        .clk_in(clk_in), .sin(sin), .xfer_done(xfer_done), .rx_overflow(rx_overflow),
        .host(hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic exp_ovf;

    always @(negedge clk) if (xfer_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hif.host_tx_valid = 1'b0;
        hif.host_rx_ready = 1'b0;
        cpu_en = 1'b1;
        console_sclk = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_q.delete();
        rx_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!hif.host_tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("push_timeout", hif.host_tx_ready, 1);
        hif.host_tx_valid = 1'b1;
        hif.host_tx_data = b;
        tx_q.push_back(b);
        @(negedge clk);
        hif.host_tx_valid = 1'b0;
    endtask

    task automatic m_rx(input logic [7:0] b, input bit popping);
        if (popping) void'(rx_q.pop_front());
        if (rx_q.size() < FD) rx_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    // Console as clock master, cpu_en held high; each SCLK phase lasts two clocks.
    task automatic cm_byte(input logic [7:0] so, input bit pop_end);
        logic [7:0] got, exp;
        int d0;
        d0 = done_cnt;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            console_sclk = 1'b0;
            console_sout = so[i];
            @(negedge clk);
            @(negedge clk);
            got[i] = sin;
            console_sclk = 1'b1;
            if (i == 0 && pop_end) begin
                hif.host_rx_ready = 1'b1;
                chk("pop_head", hif.host_rx_data, rx_q[0]);
            end
            @(negedge clk);
            hif.host_rx_ready = 1'b0;
            @(negedge clk);
        end
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : IDLE;
        chk("cm_sin", got, exp);
        chk("cm_done", done_cnt - d0, 1);
        m_rx(so, pop_end);
    endtask

    task automatic drain();
        while (rx_q.size() > 0) begin
            @(negedge clk);
            chk("rx_valid", hif.host_rx_valid, 1);
            chk("rx_data", hif.host_rx_data, rx_q.pop_front());
            hif.host_rx_ready = 1'b1;
            @(negedge clk);
            hif.host_rx_ready = 1'b0;
        end
        @(negedge clk);
        chk("rx_empty", hif.host_rx_valid, 0);
    endtask

    // Acts as the slave console: watches clk_in, feeds sout, measures phase lengths in cpu_en ticks.
    task automatic slave_run(input int nbytes, input int abort_bits);
        int bits, got_n, low_t, high_t, cyc;
        logic last, cur_c, en_prev;
        logic [7:0] sh, ob, e;
        bits = 0; got_n = 0; low_t = 0; high_t = 0; sh = 8'h00; ob = 8'h00;
        last = clk_in;
        en_prev = cpu_en;
        for (cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            cur_c = clk_in;
            if (en_prev) begin
                if (last) high_t++;
                else low_t++;
            end
            if (last && !cur_c) begin
                if (bits == 0) begin
                    ob = 8'($urandom);
                    if (got_n > 0) chk("slv_gap", high_t >= GAP, 1);
                end else begin
                    chk("slv_high", high_t, HP);
                end
                console_sout = ob[7-bits];
                low_t = 0;
                high_t = 0;
            end
            if (!last && cur_c) begin
                chk("slv_low", low_t, HP);
                sh = {sh[6:0], sin};
                bits++;
                high_t = 0;
                if (bits == 8) begin
                    e = (tx_q.size() > 0) ? tx_q.pop_front() : IDLE;
                    chk("slv_sin", sh, e);
                    m_rx(ob, 1'b0);
                    got_n++;
                    bits = 0;
                end
            end
            last = cur_c;
            if ((nbytes > 0 && got_n == nbytes) || (abort_bits > 0 && bits == abort_bits)) break;
            en_prev = ($urandom_range(3) != 0);
            cpu_en = en_prev;
        end
        if (cyc >= 20000) chk("slv_timeout", got_n, nbytes);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0, lows;
        reset = 1'b1; cpu_en = 1'b1; clk_dir = 1'b1;
        console_sclk = 1'b1; console_sout = 1'b1;
        hif.host_tx_valid = 1'b0; hif.host_tx_data = 8'h00; hif.host_rx_ready = 1'b0;
        exp_ovf = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_clk_in", clk_in, 1);
        chk("rst_sin", sin, 1);
        chk("rst_tx_ready", hif.host_tx_ready, 1);
        chk("rst_rx_valid", hif.host_rx_valid, 0);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_ovf", rx_overflow, 0);

        // console master, known bytes
        push(8'hA5);
        cm_byte(8'h3C, 1'b0);
        chk("cm_rx_data", hif.host_rx_data, 8'h3C);
        drain();
        cm_byte(8'($urandom), 1'b0);
        drain();
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1) == 1) push(8'($urandom));
            cm_byte(8'($urandom), 1'b0);
        end
        chk("ovf_none", rx_overflow, exp_ovf);
        drain();

        // RX overflow: five transfers, no pops
        do_reset();
        for (int k = 0; k < 5; k++) push(8'($urandom));
        chk("tx_full", hif.host_tx_ready, 0);
        for (int k = 0; k < 5; k++) cm_byte(8'($urandom), 1'b0);
        chk("ovf_set", rx_overflow, exp_ovf);
        drain();

        // same, but the host pops on the fifth completion
        do_reset();
        for (int k = 0; k < 5; k++) push(8'($urandom));
        for (int k = 0; k < 5; k++) cm_byte(8'($urandom), k == 4);
        chk("ovf_pop", rx_overflow, exp_ovf);
        drain();

        // partner as clock master
        clk_dir = 1'b0;
        do_reset();
        cpu_en = 1'b0;
        push(8'h81);
        push(8'h42);
        slave_run(2, -1);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!clk_in) lows++;
            cpu_en = ($urandom_range(3) != 0);
        end
        chk("idle_high", lows, 0);
        drain();

        // direction flip mid-byte, then full resend
        do_reset();
        cpu_en = 1'b0;
        push(8'hF0);
        slave_run(0, 3);
        d0 = done_cnt;
        @(negedge clk);
        clk_dir = 1'b1;
        cpu_en = 1'b1;
        @(negedge clk);
        chk("abort_clk_in", clk_in, 1);
        repeat (3) @(negedge clk);
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_rxv", hif.host_rx_valid, 0);
        clk_dir = 1'b0;
        @(negedge clk);
        slave_run(1, -1);
        drain();

        // reset in the middle of bit 5
        clk_dir = 1'b1;
        do_reset();
        cm_byte(8'($urandom), 1'b0);
        push(8'h00);
        for (int k = 0; k < 4; k++) push(8'($urandom));
        chk("tx_full2", hif.host_tx_ready, 0);
        cpu_en = 1'b0;
        @(negedge clk);
        clk_dir = 1'b0;
        slave_run(0, 4);
        cpu_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!clk_in) break;
        end
        chk("mid_clk_low", clk_in, 0);
        chk("mid_sin", sin, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_clk_in", clk_in, 1);
        chk("mrst_sin", sin, 1);
        chk("mrst_rx_valid", hif.host_rx_valid, 0);
        chk("mrst_tx_ready", hif.host_tx_ready, 1);
        chk("mrst_ovf", rx_overflow, 0);
        chk("mrst_done", xfer_done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
